// File: rtl/l2_mesi_dir_ctrl.sv
// L2 MESI directory controller: tags, MESI state and LRU ages per set.
// Optional hit/miss statistics counters under the L2_STATS_EN macro.
module l2_mesi_dir_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 6,
  parameter int WAYS     = 8,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  output logic                     rsp_hit,
  output logic [$clog2(WAYS)-1:0]  rsp_way,
  output logic                     bus_valid,
  output logic [1:0]               bus_op,
  output logic [ADDR_W-1:0]        bus_addr,
  input  logic                     bus_ready,
  input  logic                     bus_shared,
  input  logic                     snp_valid,
  output logic                     snp_ready,
  input  logic [1:0]               snp_op,
  input  logic [ADDR_W-1:0]        snp_addr,
  output logic                     snp_done,
  output logic                     snp_hit,
  output logic                     snp_hitm,
  output logic [CNT_W-1:0]         hit_cnt,
  output logic [CNT_W-1:0]         miss_cnt
);

  localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int SETS   = 2 ** INDEX_W;
  localparam int LINE_W = ADDR_W - OFFSET_W;

  localparam logic [1:0] OP_DW  = 2'b01;
  localparam logic [1:0] OP_NOP = 2'b11;
  localparam logic [1:0] B_READ = 2'b00;
  localparam logic [1:0] B_RFO  = 2'b01;
  localparam logic [1:0] B_WB   = 2'b10;
  localparam logic [1:0] SNP_R  = 2'b00;

  typedef enum logic [1:0] {
    MS_I, MS_S, MS_E, MS_M
  } mesi_e;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB, FILL,
    UPG, RESP, SNOOP, SNP_WB
  } state_e;

  logic [TAG_W-1:0] tag_q [SETS][WAYS];
  mesi_e            st_q  [SETS][WAYS];
  logic [WAY_W-1:0] age_q [SETS][WAYS];

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [WAY_W-1:0]  way_q, way_d;
  logic              hit_q, hit_d;
  logic [TAG_W-1:0]  vtag_q, vtag_d;
  logic              acc_q;
  logic              sdone_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   ltag;
  logic               lk_hit;
  logic [WAY_W-1:0]   lk_way;
  mesi_e              lk_st;
  logic               inv_ok;
  logic [WAY_W-1:0]   inv_way;
  logic [WAY_W-1:0]   lru_way;
  logic [WAY_W-1:0]   vic_way;
  logic               snp_m;
  logic               bus_acc;

  logic             dir_we;
  logic [WAY_W-1:0] dir_way;
  mesi_e            dir_st;
  logic             lru_we;

  logic unused_ok;
  assign unused_ok = ^{req_addr[OFFSET_W-1:0],
                       snp_addr[OFFSET_W-1:0]};

  assign idx  = line_q[INDEX_W-1:0];
  assign ltag = line_q[LINE_W-1:INDEX_W];

  // Tag match, first free way and LRU way of the addressed set
  always_comb begin
    lk_hit  = 1'b0;
    lk_way  = '0;
    inv_ok  = 1'b0;
    inv_way = '0;
    lru_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (st_q[idx][w] != MS_I &&
          tag_q[idx][w] == ltag && !lk_hit) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
      if (st_q[idx][w] == MS_I && !inv_ok) begin
        inv_ok  = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (age_q[idx][w] == WAY_W'(WAYS - 1)) begin
        lru_way = WAY_W'(w);
      end
    end
  end

  assign lk_st   = st_q[idx][lk_way];
  assign vic_way = inv_ok ? inv_way : lru_way;
  assign snp_m   = lk_hit && (lk_st == MS_M);
  assign bus_acc = bus_valid && bus_ready;

  // Controller next state and directory write strobes
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    line_d  = line_q;
    way_d   = way_q;
    hit_d   = hit_q;
    vtag_d  = vtag_q;
    dir_we  = 1'b0;
    dir_way = way_q;
    dir_st  = MS_I;
    lru_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (snp_valid) begin
          op_d    = snp_op;
          line_d  = snp_addr[ADDR_W-1:OFFSET_W];
          state_d = SNOOP;
        end else if (req_valid) begin
          op_d    = req_op;
          line_d  = req_addr[ADDR_W-1:OFFSET_W];
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (op_q == OP_NOP) begin
          hit_d   = 1'b0;
          way_d   = '0;
          state_d = RESP;
        end else if (lk_hit) begin
          hit_d = 1'b1;
          way_d = lk_way;
          if (op_q == OP_DW && lk_st == MS_S) begin
            state_d = UPG;
          end else begin
            state_d = RESP;
            if (op_q == OP_DW) begin
              dir_we  = 1'b1;
              dir_way = lk_way;
              dir_st  = MS_M;
            end
          end
        end else begin
          hit_d   = 1'b0;
          way_d   = vic_way;
          vtag_d  = tag_q[idx][vic_way];
          state_d = (st_q[idx][vic_way] == MS_M)
                    ? WB : FILL;
        end
      end
      WB: begin
        if (bus_acc) state_d = FILL;
      end
      FILL: begin
        if (bus_acc) begin
          dir_we  = 1'b1;
          dir_st  = (op_q == OP_DW) ? MS_M :
                    bus_shared ? MS_S : MS_E;
          state_d = RESP;
        end
      end
      UPG: begin
        if (bus_acc) begin
          dir_we  = 1'b1;
          dir_st  = MS_M;
          state_d = RESP;
        end
      end
      RESP: begin
        lru_we  = (op_q != OP_NOP);
        state_d = IDLE;
      end
      SNOOP: begin
        way_d = lk_way;
        if (snp_m) begin
          state_d = SNP_WB;
        end else begin
          state_d = IDLE;
          if (lk_hit) begin
            dir_we  = 1'b1;
            dir_way = lk_way;
            dir_st  = (op_q == SNP_R) ? MS_S : MS_I;
          end
        end
      end
      SNP_WB: begin
        if (bus_acc) begin
          dir_we  = 1'b1;
          dir_st  = (op_q == SNP_R) ? MS_S : MS_I;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      line_q  <= '0;
      way_q   <= '0;
      hit_q   <= 1'b0;
      vtag_q  <= '0;
      acc_q   <= 1'b0;
      sdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      line_q  <= line_d;
      way_q   <= way_d;
      hit_q   <= hit_d;
      vtag_q  <= vtag_d;
      acc_q   <= bus_acc;
      sdone_q <= (state_q == SNP_WB) && bus_acc;
    end
  end

  // Directory arrays: tag/MESI writes and LRU age update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w] <= '0;
          st_q[s][w]  <= MS_I;
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else begin
      if (dir_we) begin
        tag_q[idx][dir_way] <= ltag;
        st_q[idx][dir_way]  <= dir_st;
      end
      if (lru_we) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == way_q) begin
            age_q[idx][w] <= '0;
          end else if (age_q[idx][w] <
                       age_q[idx][way_q]) begin
            age_q[idx][w] <= age_q[idx][w] + 1'b1;
          end
        end
      end
    end
  end

  // Bus request; gap cycle after every accepted transaction
  always_comb begin
    bus_valid = 1'b0;
    bus_op    = B_READ;
    bus_addr  = '0;
    if (!acc_q) begin
      unique case (state_q)
        WB: begin
          bus_valid = 1'b1;
          bus_op    = B_WB;
          bus_addr  = {vtag_q, idx, {OFFSET_W{1'b0}}};
        end
        FILL: begin
          bus_valid = 1'b1;
          bus_op    = (op_q == OP_DW) ? B_RFO : B_READ;
          bus_addr  = {line_q, {OFFSET_W{1'b0}}};
        end
        UPG: begin
          bus_valid = 1'b1;
          bus_op    = B_RFO;
          bus_addr  = {line_q, {OFFSET_W{1'b0}}};
        end
        SNP_WB: begin
          bus_valid = 1'b1;
          bus_op    = B_WB;
          bus_addr  = {line_q, {OFFSET_W{1'b0}}};
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE) && !snp_valid;
  assign snp_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_hit   = (state_q == RESP) && hit_q;
  assign rsp_way   = (state_q == RESP) ? way_q : '0;

  assign snp_done = ((state_q == SNOOP) && !snp_m) ||
                    sdone_q;
  assign snp_hit  = ((state_q == SNOOP) && lk_hit &&
                     !snp_m) || sdone_q;
  assign snp_hitm = sdone_q;

`ifdef L2_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;
  logic             look_acc;

  assign look_acc = (state_q == LOOKUP) &&
                    (op_q != OP_NOP);

  // Saturating hit/miss counters, one count per lookup
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (look_acc) begin
      if (lk_hit && hit_cnt_q != '1)
        hit_cnt_q <= hit_cnt_q + 1'b1;
      if (!lk_hit && miss_cnt_q != '1)
        miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_l2_mesi_dir_ctrl.sv
// Bench for l2_mesi_dir_ctrl: directed steps then random traffic
// checked against a line-level MESI/LRU reference model.
module tb_l2_mesi_dir_ctrl;

  localparam int SETS = 64;
  localparam int WAYS = 8;

  localparam logic [1:0] DR = 0, DW = 1, IR = 2, NOP = 3;
  localparam logic [1:0] BRD = 0, BRFO = 1, BWB = 2;
  localparam logic [1:0] SR = 0, SRFO = 1, SINV = 2;
  localparam int MI = 0, MS = 1, ME = 2, MM = 3;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        req_valid = 0;
  logic        req_ready;
  logic [1:0]  req_op = 0;
  logic [31:0] req_addr = 0;
  logic        rsp_valid, rsp_hit;
  logic [2:0]  rsp_way;
  logic        bus_valid;
  logic [1:0]  bus_op;
  logic [31:0] bus_addr;
  logic        bus_ready = 0;
  logic        bus_shared = 0;
  logic        snp_valid = 0;
  logic        snp_ready;
  logic [1:0]  snp_op = 0;
  logic [31:0] snp_addr = 0;
  logic        snp_done, snp_hit, snp_hitm;
  logic [15:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  l2_mesi_dir_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
    .rsp_way(rsp_way),
    .bus_valid(bus_valid), .bus_op(bus_op),
    .bus_addr(bus_addr), .bus_ready(bus_ready),
    .bus_shared(bus_shared),
    .snp_valid(snp_valid), .snp_ready(snp_ready),
    .snp_op(snp_op), .snp_addr(snp_addr),
    .snp_done(snp_done), .snp_hit(snp_hit),
    .snp_hitm(snp_hitm),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] addr;
  } txn_t;

  int checks = 0;
  int errors = 0;

  logic [19:0] m_tag [SETS][WAYS];
  int          m_st  [SETS][WAYS];
  int          m_use [SETS][WAYS];
  int          tick;
  int          m_hits, m_miss;
  txn_t        exp_q[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_tag[s][w] = '0;
        m_st[s][w]  = MI;
        m_use[s][w] = -w;
      end
    end
    tick   = 0;
    m_hits = 0;
    m_miss = 0;
    exp_q.delete();
  endtask

  task automatic push_txn(input logic [1:0] op,
                          input logic [31:0] a);
    txn_t t;
    t.op   = op;
    t.addr = a;
    exp_q.push_back(t);
  endtask

  // Serve bus transactions until done_sig; returns bus count
  task automatic serve(input bit is_snp, input bit shared,
                       input int stall, output int nbus,
                       output int lat, output bit got);
    int held;
    bit drop;
    logic [1:0]  h_op;
    logic [31:0] h_addr;
    held = 0; drop = 0; nbus = 0; lat = 0; got = 0;
    h_op = 0; h_addr = 0;
    for (int c = 1; c <= 80 && !got; c++) begin
      if (c > 1) @(negedge clk);
      bus_ready = 0;
      if (drop) begin
        chk("bus_drop", bus_valid, 0);
        drop = 0;
      end
      if (is_snp ? snp_done : rsp_valid) begin
        got = 1;
        lat = c;
      end else if (bus_valid) begin
        if (held == 0) begin
          if (exp_q.size() == 0) begin
            chk("bus_unexpected", bus_valid, 0);
          end else begin
            chk("bus_op", bus_op, exp_q[0].op);
            chk("bus_addr", bus_addr, exp_q[0].addr);
          end
          h_op = bus_op;
          h_addr = bus_addr;
        end else begin
          chk("bus_hold_op", bus_op, h_op);
          chk("bus_hold_addr", bus_addr, h_addr);
        end
        if (held >= stall) begin
          bus_ready  = 1;
          bus_shared = shared;
          held = 0;
          drop = 1;
          nbus++;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
          held++;
        end
      end else if (held > 0) begin
        chk("bus_hold_valid", bus_valid, 1);
        held = 0;
      end
    end
    bus_ready = 0;
  endtask

  task automatic do_req(input logic [1:0] op,
                        input logic [31:0] a,
                        input bit shared, input int stall);
    logic [5:0]  s;
    logic [19:0] tg;
    logic [31:0] line;
    bit hit, got;
    int way, vic, nexp, nbus, lat;
    s = a[11:6];
    tg = a[31:12];
    line = {a[31:6], 6'b0};
    hit = 0; way = 0;
    exp_q.delete();
    if (op != NOP) begin
      for (int w = 0; w < WAYS; w++) begin
        if (m_st[s][w] != MI && m_tag[s][w] == tg && !hit) begin
          hit = 1;
          way = w;
        end
      end
      if (hit) begin
        m_hits++;
        if (op == DW) begin
          if (m_st[s][way] == MS) push_txn(BRFO, line);
          m_st[s][way] = MM;
        end
      end else begin
        m_miss++;
        vic = -1;
        for (int w = 0; w < WAYS; w++)
          if (m_st[s][w] == MI && vic < 0) vic = w;
        if (vic < 0) begin
          vic = 0;
          for (int w = 1; w < WAYS; w++)
            if (m_use[s][w] < m_use[s][vic]) vic = w;
        end
        way = vic;
        if (m_st[s][vic] == MM)
          push_txn(BWB, {m_tag[s][vic], s, 6'b0});
        push_txn(op == DW ? BRFO : BRD, line);
        m_tag[s][vic] = tg;
        m_st[s][vic] = (op == DW) ? MM : shared ? MS : ME;
      end
      tick++;
      m_use[s][way] = tick;
    end
    nexp = exp_q.size();
    @(negedge clk);
    req_valid = 1;
    req_op = op;
    req_addr = a;
    #1 chk("req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 0;
    serve(0, shared, stall, nbus, lat, got);
    if (!got) begin
      chk("rsp_timeout", rsp_valid, 1);
    end else begin
      chk("rsp_hit", rsp_hit, hit);
      if (op != NOP) chk("rsp_way", rsp_way, way);
      if (nexp == 0) chk("rsp_latency", lat, 2);
    end
    chk("req_bus_count", nbus, nexp);
  endtask

  task automatic snp_model(input logic [1:0] op,
                           input logic [31:0] a,
                           output bit hit, output bit hitm);
    logic [5:0] s;
    int way;
    s = a[11:6];
    hit = 0; hitm = 0; way = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (m_st[s][w] != MI && m_tag[s][w] == a[31:12] && !hit) begin
        hit = 1;
        way = w;
      end
    end
    if (hit) begin
      hitm = (m_st[s][way] == MM);
      if (hitm) push_txn(BWB, {a[31:6], 6'b0});
      m_st[s][way] = (op == SR) ? MS : MI;
    end
  endtask

  task automatic do_snp(input logic [1:0] op,
                        input logic [31:0] a, input int stall);
    bit hit, hitm, got;
    int nexp, nbus, lat;
    exp_q.delete();
    snp_model(op, a, hit, hitm);
    nexp = exp_q.size();
    @(negedge clk);
    snp_valid = 1;
    snp_op = op;
    snp_addr = a;
    #1 chk("snp_ready", snp_ready, 1);
    chk("snp_blocks_req", req_ready, 0);
    @(negedge clk);
    snp_valid = 0;
    serve(1, 0, stall, nbus, lat, got);
    if (!got) begin
      chk("snp_timeout", snp_done, 1);
    end else begin
      chk("snp_hit", snp_hit, hit);
      chk("snp_hitm", snp_hitm, hitm);
      if (!hitm) chk("snp_latency", lat, 1);
    end
    chk("snp_bus_count", nbus, nexp);
  endtask

  task automatic chk_cnt(input string tag);
`ifdef L2_STATS_EN
    chk({tag, "_hit"}, hit_cnt, m_hits);
    chk({tag, "_miss"}, miss_cnt, m_miss);
`else
    chk({tag, "_hit"}, hit_cnt, 0);
    chk({tag, "_miss"}, miss_cnt, 0);
`endif
  endtask

  initial begin
    bit ph, phm;
    bit seen;
    logic [31:0] ra;
    logic [5:0]  rs;
    model_reset();
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_snp_ready", snp_ready, 1);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_snp_done", snp_done, 0);
    chk_cnt("rst_cnt");
    @(negedge clk);
    rst_n = 1;

    do_req(DR, 32'h0000_1040, 0, 0);
    do_req(DR, 32'h0000_1040, 0, 0);
    do_req(DR, 32'h0000_2000, 1, 0);
    do_req(DW, 32'h0000_2000, 0, 0);

    for (int t = 0; t < 9; t++)
      do_req(DW, (32'(t + 16) << 12) | 32'h80, 0,
             (t == 8) ? 5 : 0);

    do_req(DW, 32'h0000_3000, 0, 0);
    do_snp(SR, 32'h0000_3000, 0);
    do_snp(SINV, 32'h0000_3000, 0);
    do_req(DR, 32'h0000_3000, 0, 0);

    // simultaneous snoop and request: snoop wins
    exp_q.delete();
    snp_model(SR, 32'h0000_1040, ph, phm);
    @(negedge clk);
    snp_valid = 1; snp_op = SR; snp_addr = 32'h0000_1040;
    req_valid = 1; req_op = DR; req_addr = 32'h0000_2000;
    #1 chk("prio_req_ready", req_ready, 0);
    @(negedge clk);
    snp_valid = 0;
    chk("prio_snp_done", snp_done, 1);
    chk("prio_snp_hit", snp_hit, ph);
    chk("prio_req_wait", req_ready, 0);
    chk("prio_no_rsp", rsp_valid, 0);
    req_valid = 0;
    do_req(DR, 32'h0000_2000, 0, 0);

    // reset in the middle of a fill
    @(negedge clk);
    req_valid = 1; req_op = DR; req_addr = 32'h0000_70C0;
    @(negedge clk);
    req_valid = 0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (bus_valid) seen = 1;
      else @(negedge clk);
    end
    chk("fill_seen", bus_valid, 1);
    #2 rst_n = 0;
    #1 chk("rst_mid_bus_valid", bus_valid, 0);
    chk("rst_mid_req_ready", req_ready, 1);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    model_reset();
    chk_cnt("rst_mid_cnt");
    @(negedge clk);
    rst_n = 1;

    do_req(DR, 32'h0000_1040, 0, 0);
    do_req(DR, 32'h0000_1040, 0, 0);
    do_req(IR, 32'h0000_1040, 0, 0);
    do_req(NOP, 32'h0000_1040, 0, 0);
    do_req(DW, 32'h0000_5000, 0, 0);
    do_req(DR, 32'h0000_5000, 0, 0);
    chk_cnt("stats");

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0: rs = 6'd0;
        1: rs = 6'd1;
        default: rs = 6'd5;
      endcase
      ra = {12'h0, 8'($urandom_range(0, 11)), rs,
            6'($urandom_range(0, 63))};
      if ($urandom_range(0, 9) < 7)
        do_req(2'($urandom_range(0, 3)), ra,
               1'($urandom_range(0, 1)),
               $urandom_range(0, 2));
      else
        do_snp(2'($urandom_range(0, 2)), ra,
               $urandom_range(0, 2));
    end
    chk_cnt("final_cnt");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
